// File: rtl/wide_lfsr_sequencer_if.sv
// rtl/wide_lfsr_sequencer_if.sv - host/sink handshake bundle for the wide LFSR sequencer
interface wide_lfsr_sequencer_if #(
  parameter int CHUNK = 64,
  parameter int CNT_W = 16
);
  // job control
  logic             start;
  logic [CNT_W-1:0] num_cycles;
  logic             busy;
  logic             done;

  // seed stream, most-significant word first
  logic             seed_valid;
  logic [CHUNK-1:0] seed_data;
  logic             seed_ready;

  // result stream, most-significant word first
  logic             out_valid;
  logic [CHUNK-1:0] out_data;
  logic             out_last;
  logic             out_ready;

  // host / bench side
  modport master (
    output start, num_cycles, seed_valid, seed_data, out_ready,
    input  seed_ready, out_valid, out_data, out_last, busy, done
  );

  // sequencer side
  modport slave (
    input  start, num_cycles, seed_valid, seed_data, out_ready,
    output seed_ready, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/wide_lfsr_sequencer.sv
// rtl/wide_lfsr_sequencer.sv - load / step / dump sequencer around a W-bit 3-tap shift-register signature
module wide_lfsr_sequencer #(
  parameter int W     = 4096,
  parameter int CHUNK = 64,
  parameter int TAP_A = 63,
  parameter int TAP_B = 2,
  parameter int TAP_C = 0,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wide_lfsr_sequencer_if.slave bus
);

  // number of CHUNK-wide words that make up the register
  localparam int NW   = W / CHUNK;
  localparam int WC_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DUMP = 2'd3;

  logic [1:0]       state;
  logic [W-1:0]     sreg;
  logic [CNT_W-1:0] step_cnt;
  logic [WC_W-1:0]  word_cnt;
  logic             done_q;

  logic seed_fire;
  logic out_fire;
  logic at_last_word;
  logic feedback;

  assign seed_fire    = (state == S_LOAD) && bus.seed_valid;
  assign out_fire     = (state == S_DUMP) && bus.out_ready;
  assign at_last_word = (word_cnt == LAST_WORD);
  // taps read the pre-step value, so a single XOR of the current register suffices
  assign feedback     = sreg[TAP_A] ^ sreg[TAP_B] ^ sreg[TAP_C];

  // Job sequencing: state, captured step count, word position and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      step_cnt <= '0;
      word_cnt <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            step_cnt <= bus.num_cycles;
            word_cnt <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (seed_fire) begin
            if (at_last_word) begin
              word_cnt <= '0;
              // a zero step count skips RUN entirely so the seed is dumped unchanged
              state    <= (step_cnt == '0) ? S_DUMP : S_RUN;
            end else begin
              word_cnt <= word_cnt + WC_W'(1);
            end
          end
        end
        S_RUN: begin
          step_cnt <= step_cnt - CNT_W'(1);
          if (step_cnt == CNT_W'(1)) begin
            state <= S_DUMP;
          end
        end
        default: begin
          if (out_fire) begin
            if (at_last_word) begin
              word_cnt <= '0;
              state    <= S_IDLE;
              done_q   <= 1'b1;
            end else begin
              word_cnt <= word_cnt + WC_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Wide register: shift seed in, step the LFSR, rotate out so a full dump restores it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (seed_fire) begin
            sreg <= (sreg << CHUNK) | W'(bus.seed_data);
          end
        end
        S_RUN: begin
          sreg <= {sreg[W-2:0], feedback};
        end
        S_DUMP: begin
          if (out_fire) begin
            sreg <= (sreg << CHUNK) | (sreg >> (W - CHUNK));
          end
        end
        default: begin
          sreg <= sreg;
        end
      endcase
    end
  end

  assign bus.seed_ready = (state == S_LOAD);
  assign bus.out_valid  = (state == S_DUMP);
  assign bus.out_data   = sreg[W-1 -: CHUNK];
  assign bus.out_last   = (state == S_DUMP) && at_last_word;
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_wide_lfsr_sequencer.sv
// tb/tb_wide_lfsr_sequencer.sv - scoreboard bench for wide_lfsr_sequencer (W=128, CHUNK=32)
module tb_wide_lfsr_sequencer;
  localparam int W     = 128;
  localparam int CHUNK = 32;
  localparam int CNT_W = 16;
  localparam int NW    = W / CHUNK;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wide_lfsr_sequencer_if #(.CHUNK(CHUNK), .CNT_W(CNT_W)) bus ();

  wide_lfsr_sequencer #(
    .W(W), .CHUNK(CHUNK), .TAP_A(63), .TAP_B(2), .TAP_C(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [CHUNK-1:0] sb[$];
  logic [CHUNK-1:0] exp_w;
  logic [CHUNK-1:0] got_words[NW];
  logic             got_last[NW];
  int               got_wait;
  int               got_done;
  int               done_first;
  int               busy_seen;
  int               timed_out;
  int               unstable;

  function automatic logic [W-1:0] model_run(input logic [W-1:0] s, input int n);
    logic [W-1:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = {r[W-2:0], r[63] ^ r[2] ^ r[0]};
    return r;
  endfunction

  task automatic push_model(input logic [W-1:0] seed, input int n);
    logic [W-1:0] r;
    r = model_run(seed, n);
    for (int k = 0; k < NW; k++) sb.push_back(r[W-1-CHUNK*k -: CHUNK]);
  endtask

  task automatic load_job(input logic [W-1:0] seed, input int n, input bit gaps);
    int i;
    int guard;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.num_cycles = CNT_W'(n);
    @(negedge clk);
    bus.start = 1'b0;
    i = 0;
    guard = 0;
    while (i < NW && guard < 200) begin
      bus.seed_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.seed_data  = seed[W-1-CHUNK*i -: CHUNK];
      if (bus.seed_valid && bus.seed_ready) i++;
      @(negedge clk);
      guard++;
    end
    bus.seed_valid = 1'b0;
  endtask

  task automatic collect(input bit rand_ready, input bit hold_start);
    int k;
    int cyc;
    bit seen;
    bit prev_stall;
    logic [CHUNK-1:0] prev_d;
    k = 0; cyc = 0; seen = 0; prev_stall = 0; prev_d = '0;
    got_wait = 0; got_done = 0; done_first = 0; busy_seen = 0; timed_out = 0; unstable = 0;
    if (hold_start) bus.start = 1'b1;
    while (k < NW && cyc < 2000) begin
      if (bus.out_valid) begin
        seen = 1;
        if (prev_stall && bus.out_data !== prev_d) unstable++;
        bus.out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (bus.out_ready) begin
          got_words[k] = bus.out_data;
          got_last[k]  = bus.out_last;
          k++;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_d     = bus.out_data;
        end
      end else begin
        bus.out_ready = 1'b0;
        if (!seen) got_wait++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    if (k < NW) timed_out = 1;
    for (int j = 0; j < 3; j++) begin
      if (bus.done) got_done++;
      if (j == 0) done_first = bus.done;
      if (bus.busy) busy_seen++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.seed_ready !== 1'b0) begin n_fail++; $display("FAIL reset_seed_ready: got %b expected 0", bus.seed_ready); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_seed;
    for (int k = 0; k < NW; k++) sb.push_back(32'h0);
    load_job(128'h0, 5, 0);
    collect(0, 0);
    n_checks++; if (timed_out !== 0) begin n_fail++; $display("FAIL zero_seed_timeout: got %0d expected 0", timed_out); end
    n_checks++; if (got_wait !== 5) begin n_fail++; $display("FAIL zero_seed_run_cycles: got %0d expected 5", got_wait); end
    for (int k = 0; k < NW; k++) begin
      exp_w = sb.pop_front();
      n_checks++; if (got_words[k] !== exp_w) begin n_fail++; $display("FAIL zero_seed_word%0d: got %h expected %h", k, got_words[k], exp_w); end
      n_checks++; if (got_last[k] !== (k == NW-1)) begin n_fail++; $display("FAIL zero_seed_last%0d: got %b expected %b", k, got_last[k], (k == NW-1)); end
    end
    n_checks++; if (done_first !== 1) begin n_fail++; $display("FAIL zero_seed_done_timing: got %0d expected 1", done_first); end
    n_checks++; if (got_done !== 1) begin n_fail++; $display("FAIL zero_seed_done_width: got %0d expected 1", got_done); end
  endtask

  task automatic test_single_step;
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h3);
    load_job(128'h1, 1, 0);
    collect(0, 0);
    n_checks++; if (got_wait !== 1) begin n_fail++; $display("FAIL single_step_run_cycles: got %0d expected 1", got_wait); end
    for (int k = 0; k < NW; k++) begin
      exp_w = sb.pop_front();
      n_checks++; if (got_words[k] !== exp_w) begin n_fail++; $display("FAIL single_step_word%0d: got %h expected %h", k, got_words[k], exp_w); end
    end
  endtask

  task automatic test_tap63;
    sb.push_back(32'h0); sb.push_back(32'h1); sb.push_back(32'h0); sb.push_back(32'h1);
    load_job(128'h8000_0000_0000_0000, 1, 0);
    collect(0, 0);
    for (int k = 0; k < NW; k++) begin
      exp_w = sb.pop_front();
      n_checks++; if (got_words[k] !== exp_w) begin n_fail++; $display("FAIL tap63_word%0d: got %h expected %h", k, got_words[k], exp_w); end
    end
    n_checks++; if (got_done !== 1) begin n_fail++; $display("FAIL tap63_done: got %0d expected 1", got_done); end
  endtask

  task automatic test_bypass;
    sb.push_back(32'hDEADBEEF); sb.push_back(32'h01234567); sb.push_back(32'h89ABCDEF); sb.push_back(32'hCAFEF00D);
    load_job(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0, 1);
    collect(0, 0);
    n_checks++; if (got_wait !== 0) begin n_fail++; $display("FAIL bypass_run_cycles: got %0d expected 0", got_wait); end
    for (int k = 0; k < NW; k++) begin
      exp_w = sb.pop_front();
      n_checks++; if (got_words[k] !== exp_w) begin n_fail++; $display("FAIL bypass_word%0d: got %h expected %h", k, got_words[k], exp_w); end
    end
  endtask

  task automatic test_stall;
    logic [W-1:0] seed;
    seed = {$urandom, $urandom, $urandom, $urandom};
    push_model(seed, 37);
    load_job(seed, 37, 1);
    collect(1, 0);
    n_checks++; if (timed_out !== 0) begin n_fail++; $display("FAIL stall_timeout: got %0d expected 0", timed_out); end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL stall_data_stable: got %0d changes expected 0", unstable); end
    for (int k = 0; k < NW; k++) begin
      exp_w = sb.pop_front();
      n_checks++; if (got_words[k] !== exp_w) begin n_fail++; $display("FAIL stall_word%0d: got %h expected %h", k, got_words[k], exp_w); end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] seed;
    for (int job = 0; job < 2; job++) begin
      seed = {$urandom, $urandom, $urandom, $urandom};
      push_model(seed, 3 + 50 * job);
      load_job(seed, 3 + 50 * job, job == 1);
      collect(job == 1, job == 0);
      n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL b2b_start_ignored%0d: got busy %0d cycles expected 0", job, busy_seen); end
      for (int k = 0; k < NW; k++) begin
        exp_w = sb.pop_front();
        n_checks++; if (got_words[k] !== exp_w) begin n_fail++; $display("FAIL b2b_job%0d_word%0d: got %h expected %h", job, k, got_words[k], exp_w); end
      end
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] seed;
    int done_cnt;
    seed = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    push_model(seed, 1000);
    load_job(seed, 1000, 0);
    repeat (10) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy_before: got %b expected 1", bus.busy); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrun_busy_after_reset: got %b expected 0", bus.busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_out_valid_after_reset: got %b expected 0", bus.out_valid); end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL midrun_no_done: got %0d pulses expected 0", done_cnt); end
    push_model(seed, 9);
    load_job(seed, 9, 0);
    collect(0, 0);
    n_checks++; if (got_wait !== 9) begin n_fail++; $display("FAIL midrun_rerun_cycles: got %0d expected 9", got_wait); end
    for (int k = 0; k < NW; k++) begin
      exp_w = sb.pop_front();
      n_checks++; if (got_words[k] !== exp_w) begin n_fail++; $display("FAIL midrun_rerun_word%0d: got %h expected %h", k, got_words[k], exp_w); end
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.num_cycles = '0;
    bus.seed_valid = 1'b0;
    bus.seed_data  = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_zero_seed();
    test_single_step();
    test_tap63();
    test_bypass();
    test_stall();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
